// File: rtl/dm_responder_pkg.sv
// ============================================================================
//  Module   : dm_responder_pkg
//  Purpose  : Shared definitions for the data-memory responder: FSM state
//             encodings and the wait-state counter width.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package dm_responder_pkg;

    // Wait-state counter width; bounds the WAIT parameter to 0..15.
    localparam int CNT_W = 4;

    // Responder FSM state encodings.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

endpackage

`default_nettype wire

// File: rtl/dm_responder_ws_counter.sv
// ============================================================================
//  Module   : ws_counter
//  Purpose  : Wait-state down-counter with load, decrement and zero flag.
//  Ports    : clk      in   clock
//             rst_n    in   asynchronous active-low reset
//             load     in   load load_val (has priority over dec)
//             load_val in   CNT_W  value to load
//             dec      in   decrement by one (saturates at zero)
//             cnt      out  CNT_W  current count
//             zero     out  count equals zero
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ws_counter
    import dm_responder_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             zero
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

`default_nettype wire

// File: rtl/dm_responder.sv
// ============================================================================
//  Module   : dm_responder
//  Purpose  : Target end of the CPU MEM-stage load/store interface. Serves
//             word reads/writes from an internal RAM over a req/ack handshake
//             with WAIT programmable wait states. ack arrives WAIT+1 cycles
//             after the accept edge; minimum issue period is WAIT+2 cycles.
//  Options  : DM_BYTE_EN - adds a 4-bit byte-enable port for stores.
//  Ports    : clk    in   clock
//             rst_n  in   asynchronous active-low reset
//             req    in   request, held by initiator until ack
//             wr     in   1 = store, 0 = load (sampled at accept)
//             addr   in   ADDR_W word address (sampled at accept)
//             wdata  in   32 store data (sampled at accept)
//             be     in   4 byte enables (DM_BYTE_EN only, sampled at accept)
//             rdata  out  32 load data, valid while ack=1
//             ack    out  one-cycle completion pulse
//             err    out  out-of-range flag, valid while ack=1
//             busy   out  high from cycle after accept through ack cycle
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dm_responder
    import dm_responder_pkg::*;
#(
    parameter int NMEM   = 128,
    parameter int ADDR_W = 7,
    parameter int WAIT   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
`ifdef DM_BYTE_EN
    input  logic [3:0]        be,
`endif
    output logic [31:0]       rdata,
    output logic              ack,
    output logic              err,
    output logic              busy
);

    if ((WAIT < 0) || (WAIT > 15)) begin : g_wait_range_check
        $error("dm_responder: WAIT must be in 0..15");
    end

    localparam logic [CNT_W-1:0] WAIT_LOAD = (WAIT > 0) ? CNT_W'(WAIT - 1) : '0;
    localparam logic [ADDR_W:0]  NMEM_LIM  = (ADDR_W + 1)'(NMEM);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        be_q;
    logic              accept;
    logic              in_range;
    logic              cnt_zero;
    logic [CNT_W-1:0]  cnt;
    logic [31:0]       rd_word;

    logic [31:0]       mem [0:NMEM-1];

    assign accept   = (state == ST_IDLE) && req;
    assign in_range = ({1'b0, addr_q} < NMEM_LIM);
    assign rd_word  = in_range ? mem[addr_q] : '0;

    ws_counter u_ws_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .load_val (WAIT_LOAD),
        .dec      (state == ST_WAIT),
        .cnt      (cnt),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    state_nxt = (WAIT > 0) ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                if (cnt_zero) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Control, request capture and registered outputs. The response is
    // registered at the edge that leaves RESP, so ack is seen WAIT+1 cycles
    // after the accept edge while the FSM is already back in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ack     <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b0;
            rdata   <= '0;
        end else begin
            state <= state_nxt;
            busy  <= accept || (state != ST_IDLE);
            ack   <= (state == ST_RESP);
            err   <= (state == ST_RESP) && !in_range;
            if (accept) begin
                wr_q    <= wr;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            if (state == ST_RESP) begin
                rdata <= (!wr_q && in_range) ? rd_word : '0;
            end
        end
    end

`ifdef DM_BYTE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            be_q <= '0;
        end else if (accept) begin
            be_q <= be;
        end
    end
`else
    assign be_q = 4'hF;
`endif

    // RAM is not reset. Write enable is derived from state, which the async
    // reset clears immediately, so a reset before the RESP edge blocks the
    // write entirely and whole bytes are written at a single edge.
    always_ff @(posedge clk) begin
        if ((state == ST_RESP) && wr_q && in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    mem[addr_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

endmodule

`default_nettype wire
